mem_stage: RTL and testbench

- MEM pipeline stage; consumes the EX/MEM latch outputs and drives the MEM/WB latch.
- Executes RV32I loads and stores as byte-serial transactions over the memory-controller port (8-bit RAM, little-endian).
- Back-pressures the EX/MEM latch through mem_stall until the access completes.
- Non-memory ops pass through with one-cycle latency.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_stage_load_ext.sv | 32 +++
 rtl/mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state encoding and opcode decode helpers for the MEM stage.
package mem_stage_pkg;

   localparam int OP_LEN = 5;

   localparam logic [OP_LEN-1:0] OP_NOP = 5'd0;
   localparam logic [OP_LEN-1:0] OP_ADD = 5'd1;
   localparam logic [OP_LEN-1:0] OP_LB  = 5'd16;
   localparam logic [OP_LEN-1:0] OP_LH  = 5'd17;
   localparam logic [OP_LEN-1:0] OP_LW  = 5'd18;
   localparam logic [OP_LEN-1:0] OP_LBU = 5'd19;
   localparam logic [OP_LEN-1:0] OP_LHU = 5'd20;
   localparam logic [OP_LEN-1:0] OP_SB  = 5'd21;
   localparam logic [OP_LEN-1:0] OP_SH  = 5'd22;
   localparam logic [OP_LEN-1:0] OP_SW  = 5'd23;

   localparam logic       TRUE          = 1'b1;
   localparam logic       FALSE         = 1'b0;
   localparam logic [4:0] REG_ADDR_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WB     = 2'd2
   } state_t;

   function automatic logic is_load(input logic [OP_LEN-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [OP_LEN-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_mem(input logic [OP_LEN-1:0] op);
      return is_load(op) || is_store(op);
   endfunction

   function automatic logic [2:0] byte_count(input logic [OP_LEN-1:0] op);
      logic [2:0] n;
      n = 3'd1;
      if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) n = 3'd2;
      if ((op == OP_LW) || (op == OP_SW))                   n = 3'd4;
      return n;
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Merges the incoming read byte into the partial load word and produces the
// sign/zero-extended load result for the current opcode.
module mem_stage_load_ext
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [OP_LEN-1:0] op,
   input  logic [31:0]       partial,
   input  logic [1:0]        idx,
   input  logic [7:0]        rdata,
   output logic [31:0]       word,
   output logic [XLEN-1:0]   result
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign word[8*gi +: 8] = (idx == 2'(gi)) ? rdata : partial[8*gi +: 8];
   end

   always_comb begin
      result = XLEN'(word);
      case (op)
         OP_LB:   result = XLEN'($signed(word[7:0]));
         OP_LH:   result = XLEN'($signed(word[15:0]));
         OP_LBU:  result = XLEN'(word[7:0]);
         OP_LHU:  result = XLEN'(word[15:0]);
         OP_LW:   result = XLEN'($signed(word));
         default: result = XLEN'(word);
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial RV32I loads/stores over an 8-bit controller
// port, one-cycle pass-through for other ops. Optional MEM_FWD_EN adds forwarding outputs.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              ex_mem_rdy,
   input  logic [XLEN-1:0]   mem_rd_data,
   input  logic [4:0]        mem_rd_addr,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [OP_LEN-1:0] mem_op,
   output logic              mem_stall,
   output logic              ctrl_req,
   output logic              ctrl_we,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [7:0]        ctrl_wdata,
   input  logic [7:0]        ctrl_rdata,
   input  logic              ctrl_ack,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd_addr,
   output logic [XLEN-1:0]   wb_rd_data
`ifdef MEM_FWD_EN
   ,
   output logic              fwd_we,
   output logic [4:0]        fwd_rd_addr,
   output logic [XLEN-1:0]   fwd_rd_data
`endif
);

   state_t              state_reg,       state_next;
   logic [OP_LEN-1:0]   op_reg,          op_next;
   logic [ADDR_W-1:0]   addr_reg,        addr_next;
   logic [XLEN-1:0]     data_reg,        data_next;
   logic [4:0]          rd_reg,          rd_next;
   logic [2:0]          n_reg,           n_next;
   logic [1:0]          idx_reg,         idx_next;
   logic [31:0]         buf_reg,         buf_next;
   logic                wb_valid_reg,    wb_valid_next;
   logic                wb_we_reg,       wb_we_next;
   logic [4:0]          wb_rd_addr_reg,  wb_rd_addr_next;
   logic [XLEN-1:0]     wb_rd_data_reg,  wb_rd_data_next;

   logic [31:0]         load_word;
   logic [XLEN-1:0]     load_result;
   logic [7:0]          data_bytes [4];
   logic                last_byte;

   mem_stage_load_ext #(.XLEN(XLEN)) u_load_ext (
      .op      (op_reg),
      .partial (buf_reg),
      .idx     (idx_reg),
      .rdata   (ctrl_rdata),
      .word    (load_word),
      .result  (load_result)
   );

   for (genvar gi = 0; gi < 4; gi++) begin : g_wbytes
      assign data_bytes[gi] = data_reg[8*gi +: 8];
   end

   assign last_byte = ({1'b0, idx_reg} == (n_reg - 3'd1));

   // Controller port is a pure function of the latched access, so it holds
   // steady while waiting for an ack and drops as soon as the state leaves ACCESS.
   assign ctrl_req   = (state_reg == ST_ACCESS);
   assign ctrl_we    = ctrl_req & is_store(op_reg);
   assign ctrl_addr  = ctrl_req ? (addr_reg + {{(ADDR_W-2){1'b0}}, idx_reg}) : '0;
   assign ctrl_wdata = ctrl_req ? data_bytes[idx_reg] : 8'h00;

   assign mem_stall = (state_reg == ST_ACCESS) |
                      ((state_reg == ST_IDLE) & ex_mem_rdy & is_mem(mem_op));

   assign wb_valid   = wb_valid_reg;
   assign wb_we      = wb_we_reg;
   assign wb_rd_addr = wb_rd_addr_reg;
   assign wb_rd_data = wb_rd_data_reg;

`ifdef MEM_FWD_EN
   assign fwd_we      = wb_valid_reg & wb_we_reg;
   assign fwd_rd_addr = wb_valid_reg ? wb_rd_addr_reg : REG_ADDR_ZERO;
   assign fwd_rd_data = wb_valid_reg ? wb_rd_data_reg : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         op_reg         <= OP_NOP;
         addr_reg       <= '0;
         data_reg       <= '0;
         rd_reg         <= REG_ADDR_ZERO;
         n_reg          <= 3'd0;
         idx_reg        <= 2'd0;
         buf_reg        <= 32'h0;
         wb_valid_reg   <= FALSE;
         wb_we_reg      <= FALSE;
         wb_rd_addr_reg <= REG_ADDR_ZERO;
         wb_rd_data_reg <= '0;
      end else if (rdy) begin
         state_reg      <= state_next;
         op_reg         <= op_next;
         addr_reg       <= addr_next;
         data_reg       <= data_next;
         rd_reg         <= rd_next;
         n_reg          <= n_next;
         idx_reg        <= idx_next;
         buf_reg        <= buf_next;
         wb_valid_reg   <= wb_valid_next;
         wb_we_reg      <= wb_we_next;
         wb_rd_addr_reg <= wb_rd_addr_next;
         wb_rd_data_reg <= wb_rd_data_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      op_next         = op_reg;
      addr_next       = addr_reg;
      data_next       = data_reg;
      rd_next         = rd_reg;
      n_next          = n_reg;
      idx_next        = idx_reg;
      buf_next        = buf_reg;
      wb_valid_next   = FALSE;
      wb_we_next      = FALSE;
      wb_rd_addr_next = REG_ADDR_ZERO;
      wb_rd_data_next = '0;

      case (state_reg)
         ST_IDLE: begin
            if (ex_mem_rdy) begin
               if (is_mem(mem_op)) begin
                  op_next    = mem_op;
                  addr_next  = mem_addr_i;
                  data_next  = mem_rd_data;
                  rd_next    = mem_rd_addr;
                  n_next     = byte_count(mem_op);
                  idx_next   = 2'd0;
                  buf_next   = 32'h0;
                  state_next = ST_ACCESS;
               end else begin
                  wb_valid_next   = TRUE;
                  wb_we_next      = (mem_rd_addr != REG_ADDR_ZERO);
                  wb_rd_addr_next = mem_rd_addr;
                  wb_rd_data_next = mem_rd_data;
               end
            end
         end
         ST_ACCESS: begin
            if (ctrl_ack) begin
               buf_next = load_word;
               idx_next = idx_reg + 2'd1;
               if (last_byte) begin
                  // Writeback is registered on the final ack so it is visible
                  // during the single WB cycle.
                  state_next    = ST_WB;
                  wb_valid_next = TRUE;
                  if (is_load(op_reg)) begin
                     wb_we_next      = (rd_reg != REG_ADDR_ZERO);
                     wb_rd_addr_next = rd_reg;
                     wb_rd_data_next = load_result;
                  end
               end
            end
         end
         ST_WB: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage: pass-through, loads, stores,
// rdy freeze and reset during an access.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, ex_mem_rdy;
   logic [31:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_addr_i;
   logic [4:0]  mem_op;
   logic        mem_stall, ctrl_req, ctrl_we;
   logic [31:0] ctrl_addr;
   logic [7:0]  ctrl_wdata, ctrl_rdata;
   logic        ctrl_ack;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .ex_mem_rdy  (ex_mem_rdy),
      .mem_rd_data (mem_rd_data),
      .mem_rd_addr (mem_rd_addr),
      .mem_addr_i  (mem_addr_i),
      .mem_op      (mem_op),
      .mem_stall   (mem_stall),
      .ctrl_req    (ctrl_req),
      .ctrl_we     (ctrl_we),
      .ctrl_addr   (ctrl_addr),
      .ctrl_wdata  (ctrl_wdata),
      .ctrl_rdata  (ctrl_rdata),
      .ctrl_ack    (ctrl_ack),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd_addr  (wb_rd_addr),
      .wb_rd_data  (wb_rd_data)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      int          nbytes;     // 0 = non-memory op
      logic        store;
      logic [31:0] rbytes;     // read bytes returned, byte k in [8k+7:8k]
      int          stall_at;   // freeze rdy after this byte's ack, -1 = never
      logic        exp_we;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic        chk_data;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i, input vec_t v);
      logic [31:0] exp_addr;
      logic [31:0] dword;
      @(negedge clk);
      mem_op = v.op; mem_addr_i = v.addr; mem_rd_data = v.data; mem_rd_addr = v.rd;
      ex_mem_rdy = 1'b1;
      #1;
      chk("stall_accept", 32'(mem_stall), 32'(v.nbytes != 0));
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      dword = v.data;
      for (int k = 0; k < v.nbytes; k++) begin
         if (k > 0 && v.stall_at == k - 1) begin
            rdy = 1'b0;
            for (int f = 0; f < 3; f++) begin
               @(negedge clk);
               #1;
               chk("frz_req", 32'(ctrl_req), 32'd1);
               chk("frz_addr", ctrl_addr, v.addr + 32'(k));
            end
            rdy = 1'b1;
         end
         #1;
         exp_addr = v.addr + 32'(k);
         chk("req", 32'(ctrl_req), 32'd1);
         chk("stall_access", 32'(mem_stall), 32'd1);
         chk("addr", ctrl_addr, exp_addr);
         chk("we", 32'(ctrl_we), 32'(v.store));
         if (v.store) chk("wdata", 32'(ctrl_wdata), 32'(dword[8*k +: 8]));
         ctrl_rdata = v.rbytes[8*k +: 8];
         ctrl_ack = 1'b1;
         @(negedge clk);
         ctrl_ack = 1'b0;
         ctrl_rdata = 8'h00;
      end
      #1;
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_we", 32'(wb_we), 32'(v.exp_we));
      chk("wb_rd_addr", 32'(wb_rd_addr), 32'(v.exp_rd));
      if (v.chk_data) chk("wb_rd_data", wb_rd_data, v.exp_data);
      chk("wb_req_low", 32'(ctrl_req), 32'd0);
      chk("wb_stall_low", 32'(mem_stall), 32'd0);
      @(negedge clk);
      #1;
      chk("wb_valid_drop", 32'(wb_valid), 32'd0);
      $display("vec %0d op=%0d addr=0x%08h rd=%0d -> wb_we=%0b rd=%0d data=0x%08h",
               i, v.op, v.addr, v.rd, wb_we, wb_rd_addr, wb_rd_data);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //          op      addr          data          rd  n  st    rbytes        stall exp_we rd   exp_data      chk
      vecs[0]  = '{OP_ADD, 32'h0,        32'h0000002A, 5,  0, 1'b0, 32'h0,        -1, 1'b1, 5'd5, 32'h0000002A, 1'b1};
      vecs[1]  = '{OP_LW,  32'h100,      32'h0,        3,  4, 1'b0, 32'h12345678, -1, 1'b1, 5'd3, 32'h12345678, 1'b1};
      vecs[2]  = '{OP_LB,  32'h80,       32'h0,        4,  1, 1'b0, 32'h00000080, -1, 1'b1, 5'd4, 32'hFFFFFF80, 1'b1};
      vecs[3]  = '{OP_LBU, 32'h80,       32'h0,        4,  1, 1'b0, 32'h00000080, -1, 1'b1, 5'd4, 32'h00000080, 1'b1};
      vecs[4]  = '{OP_LB,  32'h80,       32'h0,        0,  1, 1'b0, 32'h00000080, -1, 1'b0, 5'd0, 32'h0,        1'b0};
      vecs[5]  = '{OP_SH,  32'h1FF,      32'hABCD1234, 8,  2, 1'b1, 32'h0,        -1, 1'b0, 5'd0, 32'h0,        1'b0};
      vecs[6]  = '{OP_LW,  32'h200,      32'h0,        7,  4, 1'b0, 32'hDEADBEEF,  1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1};
      vecs[7]  = '{OP_LH,  32'h3,        32'h0,        9,  2, 1'b0, 32'h00009234, -1, 1'b1, 5'd9, 32'hFFFF9234, 1'b1};
      vecs[8]  = '{OP_LHU, 32'h3,        32'h0,        9,  2, 1'b0, 32'h00009234, -1, 1'b1, 5'd9, 32'h00009234, 1'b1};
      vecs[9]  = '{OP_SB,  32'hFFFFFFFF, 32'h00000055, 6,  1, 1'b1, 32'h0,        -1, 1'b0, 5'd0, 32'h0,        1'b0};
      vecs[10] = '{OP_SW,  32'hFFFFFFFE, 32'h11223344, 2,  4, 1'b1, 32'h0,         0, 1'b0, 5'd0, 32'h0,        1'b0};
      vecs[11] = '{OP_NOP, 32'h0,        32'h00001234, 0,  0, 1'b0, 32'h0,        -1, 1'b0, 5'd0, 32'h00001234, 1'b1};

      rst = 1'b1; rdy = 1'b1; ex_mem_rdy = 1'b0; mem_rd_data = '0; mem_rd_addr = '0;
      mem_addr_i = '0; mem_op = OP_NOP; ctrl_rdata = 8'h00; ctrl_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", 32'(ctrl_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_wb_data", wb_rd_data, 32'd0);
      chk("rst_addr", ctrl_addr, 32'd0);
      $display("reset: req=%0b wb_valid=%0b stall=%0b", ctrl_req, wb_valid, mem_stall);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Reset asserted for two cycles in the middle of a word load.
      @(negedge clk);
      mem_op = OP_LW; mem_addr_i = 32'h40; mem_rd_addr = 5'd11; ex_mem_rdy = 1'b1;
      @(negedge clk);
      ex_mem_rdy = 1'b0;
      ctrl_rdata = 8'hAA; ctrl_ack = 1'b1;
      @(negedge clk);
      ctrl_ack = 1'b0;
      #1;
      chk("midrst_req_before", 32'(ctrl_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_req_drop", 32'(ctrl_req), 32'd0);
      @(negedge clk);
      #1;
      chk("midrst_req", 32'(ctrl_req), 32'd0);
      chk("midrst_stall", 32'(mem_stall), 32'd0);
      chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("postrst_wb_valid", 32'(wb_valid), 32'd0);
      chk("postrst_req", 32'(ctrl_req), 32'd0);
      $display("reset mid-access: req=%0b wb_valid=%0b stall=%0b", ctrl_req, wb_valid, mem_stall);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
